sqrt_arbiter: RTL and testbench
===============================

# sqrt_arbiter

Clocked scheduler that shares one sqrt unit (initial-value stage plus iteration, self-timed, req/fin handshake) among `NReq` requesters. Accepts operands over per-requester valid/ready, grants round-robin, sequences a four-phase handshake to the unit and returns each result with a one-hot response strobe. Sits between the clocked pipelines and the asynchronous math cluster. It is the only block that drives the unit's `req`.

## Interface
- `Width`, 32, operand/result bit width (x and y)
- `NReq`, 4, number of requesters (2..16)
- `TimeoutCycles`, 1024, WAIT-state cycle limit (used only with the timeout feature)
- `clk`  in  1  single system clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `req_valid`  in  NReq  requester i has an operand
- `req_x`  in  NReq*Width  operand for requester i, in slice [i*Width +: Width]
- `req_ready`  out  NReq  one-hot; operand of requester i accepted when valid & ready
- `rsp_valid`  out  NReq  one-hot, one-cycle result strobe to the owning requester
- `rsp_y`  out  Width  result; valid only while any `rsp_valid` bit is high
- `rsp_err`  out  1  qualifies `rsp_valid`; timeout abort (tied 0 without feature)
- `sq_req`  out  1  request to sqrt unit (level)
- `sq_x`  out  Width  operand to unit, stable whenever `sq_req`=1
- `sq_fin`  in  1  unit done, asynchronous level; high until `sq_req` falls, then low
- `sq_y`  in  Width  unit result, stable while `sq_fin`=1

## Operation
- `sq_fin` passes through a 2-flop synchronizer (`fin_s`); `sq_y` is sampled only when `fin_s`=1 (no per-bit sync).
- States: IDLE, ISSUE, WAIT, CAPTURE, RELEASE.
- IDLE: if `fin_s`=0 and any `req_valid`, assert `req_ready` on the round-robin winner only. On transfer, latch `req_x` into `sq_x`, latch the winner index into `owner`, move pointer to winner, go to ISSUE.
- ISSUE: one cycle, `sq_x` settles with `sq_req`=0; go to WAIT.
- WAIT: `sq_req`=1; when `fin_s`=1, latch `sq_y` into `rsp_y`, go to CAPTURE.
- CAPTURE: `rsp_valid[owner]`=1 for exactly this cycle, `sq_req`=0; go to RELEASE.
- RELEASE: `sq_req`=0; when `fin_s`=0, go to IDLE.
- Round-robin: search starts at pointer+1 modulo NReq; winner is first index with `req_valid`. After reset, pointer = NReq-1, so requester 0 has priority.
- `req_ready` is all-zero outside IDLE. A requester may drop `req_valid` without a transfer; no penalty.
- Result is registered; `rsp_y` holds its last value after the strobe.

## Timing
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_y`=0, `rsp_err`=0, `sq_req`=0, `sq_x`=0, state IDLE, pointer NReq-1, sync flops 0.
- Accept at edge T: ISSUE at T+1, `sq_req` high from T+2.
- `sq_fin` rise: visible as `fin_s` 2 edges later; `rsp_valid` 1 cycle after that.
- Minimum accept-to-strobe latency: 5 cycles plus unit delay.
- Next accept is possible one cycle after `fin_s` falls; back-to-back throughput is bounded by the unit's fin-fall time.
- Reset mid-operation: `sq_req` drops asynchronously. The pending result is discarded, with no `rsp_valid`.
- `sq_fin` still high after reset: IDLE stalls with no ready until `fin_s`=0.
- Simultaneous `req_valid` on all lines: each is served once per NReq grants, with no starvation.

## Configuration
- `SQRT_ARB_TIMEOUT_EN` defined:
  - WAIT runs a cycle counter, cleared on WAIT entry.
  - At `TimeoutCycles` without `fin_s`, go to CAPTURE with `rsp_err`=1 and `rsp_y`=0.
  - Then RELEASE as normal; it still waits for `fin_s`=0.
- Undefined: no counter, `rsp_err` constant 0, and WAIT can last indefinitely.

## Structure
- Shared package `sqrt_pkg`:
  - state enum (IDLE, ISSUE, WAIT, CAPTURE, RELEASE)
  - default `Width`
  - `SQRT_SYNC_STAGES`=2
- One sub-module, `rr_picker`: combinational round-robin winner from `req_valid` and pointer; outputs a one-hot grant and a binary index.
- FSM, synchronizer, latches and the optional counter live in `sqrt_arbiter`.

## Test plan
- Single request: requester 2, x=0x0000_0100. `sq_req` rises 2 cycles after accept. Unit model returns 0x10 after 7 cycles → `rsp_valid`=0b0100, `rsp_y`=0x10, `rsp_err`=0.
- All four requesters valid continuously, x=i+1. Grant order 0,1,2,3,0. Each `rsp_valid` goes to the correct bit with the matching result.
- Reset asserted in WAIT → `sq_req` 0 immediately, no `rsp_valid`. With the model holding fin high 3 cycles past reset, the first `req_ready` appears only after `fin_s` falls.
- Unit fin arrives 1 ns after `sq_req`, far shorter than a clock period → strobe exactly 3 cycles after `sq_req` rises. Latency from accept = 5 cycles.
- Timeout enabled, `TimeoutCycles`=16, model never raises fin → after 16 WAIT cycles, `rsp_valid` with `rsp_err`=1 and `rsp_y`=0.
- Requester drops `req_valid` before a transfer → no grant recorded, pointer unchanged, and the next valid requester is served.

Source files
------------

// File: rtl/sqrt_pkg.sv
// Shared types and constants for the sqrt arbiter slice.
// FSM state encoding, default operand width and synchronizer depth.
package sqrt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_CAPTURE,
    ST_RELEASE
  } state_e;

  localparam int SQRT_WIDTH       = 32;
  localparam int SQRT_SYNC_STAGES = 2;

endpackage

// File: rtl/sqrt_arbiter_rr_picker.sv
// Combinational round-robin winner select.
// Search starts one past the pointer and wraps modulo NReq.
module rr_picker
  import sqrt_pkg::*;
#(
  parameter int NReq = 4,
  parameter int IdxW = $clog2(NReq)
) (
  input  logic [NReq-1:0] valid_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [NReq-1:0] grant_o,
  output logic [IdxW-1:0] idx_o,
  output logic            any_o
);

  logic [IdxW-1:0] cand;

  // first valid index after the pointer wins
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    cand    = '0;
    for (int i = 1; i <= NReq; i++) begin
      cand = IdxW'((int'(ptr_i) + i) % NReq);
      if (!any_o && valid_i[cand]) begin
        any_o         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = cand;
      end
    end
  end

endmodule

// File: rtl/sqrt_arbiter.sv
// Shares one self-timed sqrt unit among NReq requesters (req/fin four-phase).
// Optional WAIT timeout abort: define SQRT_ARB_TIMEOUT_EN.
module sqrt_arbiter
  import sqrt_pkg::*;
#(
  parameter int Width         = SQRT_WIDTH,
  parameter int NReq          = 4,
  parameter int TimeoutCycles = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NReq-1:0]       req_valid,
  input  logic [NReq*Width-1:0] req_x,
  output logic [NReq-1:0]       req_ready,
  output logic [NReq-1:0]       rsp_valid,
  output logic [Width-1:0]      rsp_y,
  output logic                  rsp_err,
  output logic                  sq_req,
  output logic [Width-1:0]      sq_x,
  input  logic                  sq_fin,
  input  logic [Width-1:0]      sq_y
);

  localparam int IdxW = $clog2(NReq);

  state_e state_q, state_d;

  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic [Width-1:0] x_q, x_d;
  logic [Width-1:0] y_q, y_d;
  logic sq_req_q, sq_req_d;
  logic rdy_en_q;

  logic [SQRT_SYNC_STAGES-1:0] sync_q;
  logic fin_s;

  logic [NReq-1:0] grant;
  logic [IdxW-1:0] win;
  logic any;
  logic accept;
  logic timeout;

  assign fin_s = sync_q[SQRT_SYNC_STAGES-1];

  // fin comes from the async cluster; only the level is synchronized
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SQRT_SYNC_STAGES-2:0], sq_fin};
  end

  rr_picker #(
    .NReq (NReq),
    .IdxW (IdxW)
  ) u_pick (
    .valid_i (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .idx_o   (win),
    .any_o   (any)
  );

  assign req_ready =
    (state_q == ST_IDLE && !fin_s && rdy_en_q && any) ? grant : '0;
  assign accept = |(req_ready & req_valid);

`ifdef SQRT_ARB_TIMEOUT_EN
  localparam int CntW = $clog2(TimeoutCycles + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic err_q, err_d;

  assign timeout = (state_q == ST_WAIT) && !fin_s &&
                   (cnt_q == CntW'(TimeoutCycles - 1));

  // count WAIT cycles; cleared in every other state
  always_comb begin
    cnt_d = '0;
    err_d = err_q;
    if (state_q == ST_WAIT) begin
      cnt_d = cnt_q + 1'b1;
      err_d = timeout;
    end
  end

  // timeout counter and abort flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign rsp_err = err_q && (state_q == ST_CAPTURE);
`else
  assign timeout = 1'b0;
  assign rsp_err = 1'b0;
`endif

  // next-state, operand/result latches and pointer update
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    x_d     = x_q;
    y_d     = y_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          x_d     = req_x[win*Width +: Width];
          owner_d = win;
          ptr_d   = win;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (fin_s) begin
          y_d     = sq_y;
          state_d = ST_CAPTURE;
        end else if (timeout) begin
          y_d     = '0;
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: state_d = ST_RELEASE;
      ST_RELEASE: begin
        if (!fin_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // req rises one cycle into WAIT so sq_x has a full settle cycle
    sq_req_d = (state_q == ST_WAIT) && (state_d == ST_WAIT);
  end

  // state and datapath registers; reset drops sq_req at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ptr_q    <= IdxW'(NReq - 1);
      owner_q  <= '0;
      x_q      <= '0;
      y_q      <= '0;
      sq_req_q <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      x_q      <= x_d;
      y_q      <= y_d;
      sq_req_q <= sq_req_d;
      rdy_en_q <= 1'b1;
    end
  end

  // one-cycle response strobe to the owner
  always_comb begin
    rsp_valid = '0;
    if (state_q == ST_CAPTURE) rsp_valid[owner_q] = 1'b1;
  end

  assign sq_req = sq_req_q;
  assign sq_x   = x_q;
  assign rsp_y  = y_q;

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Bench for sqrt_arbiter: async unit model plus result scoreboard.
// Timeout scenario follows SQRT_ARB_TIMEOUT_EN.
module tb_sqrt_arbiter;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int TO = 16;

  typedef struct {
    int          idx;
    logic [31:0] y;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [N-1:0] req_valid = '0;
  logic [N*W-1:0] req_x = '0;
  logic [N-1:0] req_ready;
  logic [N-1:0] rsp_valid;
  logic [W-1:0] rsp_y;
  logic rsp_err;
  logic sq_req;
  logic [W-1:0] sq_x;
  logic sq_fin = 1'b0;
  logic [W-1:0] sq_y = '0;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int rsp_cnt = 0;
  int acc_cyc = 0;
  int sqreq_cyc = 0;
  int rsp_cyc = 0;
  logic [N-1:0] last_rv = '0;
  logic [31:0] last_y = '0;
  logic last_err = 1'b0;
  logic prev_sq = 1'b0;
  int mon_k;
  exp_t sb_q[$];
  exp_t e;
  int grant_q[$];

  int fin_dly = 3;
  int fall_dly = 1;
  bit never_fin = 1'b0;
  logic [31:0] xc;

  sqrt_arbiter #(
    .Width         (W),
    .NReq          (N),
    .TimeoutCycles (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_x     (req_x),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_y     (rsp_y),
    .rsp_err   (rsp_err),
    .sq_req    (sq_req),
    .sq_x      (sq_x),
    .sq_fin    (sq_fin),
    .sq_y      (sq_y)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] isqrt(input logic [31:0] x);
    longint r = 0;
    longint t;
    for (int b = 15; b >= 0; b--) begin
      t = r | (longint'(1) << b);
      if (t * t <= longint'(x)) r = t;
    end
    return r[31:0];
  endfunction

  // self-timed unit: fin after a delay, drops after req falls
  always begin
    @(posedge sq_req);
    xc = sq_x;
    if (!never_fin) begin
      if (fin_dly == 0) #1;
      else begin
        repeat (fin_dly) @(posedge clk);
        #2;
      end
      sq_y = isqrt(xc);
      sq_fin = 1'b1;
    end
    wait (!sq_req);
    if (!never_fin) begin
      repeat (fall_dly) @(posedge clk);
      #2;
      sq_fin = 1'b0;
    end
  end

  // scoreboard: push on accept, pop and compare on strobe
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      prev_sq = 1'b0;
    end else begin
      if (sq_req && !prev_sq) sqreq_cyc = cyc;
      prev_sq = sq_req;
      if (|(req_valid & req_ready)) begin
        mon_k = 0;
        for (int i = 0; i < N; i++) if (req_ready[i]) mon_k = i;
        total_cnt++;
        if (!$onehot(req_ready))
          $display("FAIL ready_onehot got %b want one-hot", req_ready);
        else pass_cnt++;
        e.idx = mon_k;
        e.err = never_fin;
        e.y = never_fin ? 32'd0 : isqrt(req_x[mon_k*W +: W]);
        sb_q.push_back(e);
        grant_q.push_back(mon_k);
        acc_cnt++;
        acc_cyc = cyc + 1;
      end
      if (rsp_valid != '0) begin
        rsp_cnt++;
        rsp_cyc = cyc;
        last_rv = rsp_valid;
        last_y = rsp_y;
        last_err = rsp_err;
        total_cnt++;
        if (sb_q.size() == 0) begin
          $display("FAIL rsp_unexpected got rsp_valid=%b want none", rsp_valid);
        end else begin
          pass_cnt++;
          e = sb_q.pop_front();
          total_cnt++;
          if (rsp_valid !== N'(1 << e.idx))
            $display("FAIL rsp_owner got %b want %b", rsp_valid, N'(1 << e.idx));
          else pass_cnt++;
          total_cnt++;
          if (rsp_y !== e.y)
            $display("FAIL rsp_y got %h want %h", rsp_y, e.y);
          else pass_cnt++;
          total_cnt++;
          if (rsp_err !== e.err)
            $display("FAIL rsp_err got %b want %b", rsp_err, e.err);
          else pass_cnt++;
        end
      end
    end
  end

  task automatic issue(input int r, input logic [31:0] x, output bit ok);
    int a0;
    a0 = acc_cnt;
    req_x[r*W +: W] = x;
    req_valid[r] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (acc_cnt != a0) ok = 1'b1;
    end
    req_valid[r] = 1'b0;
  endtask

  task automatic wait_rsp(input int target, output bit ok);
    ok = (rsp_cnt >= target);
    for (int i = 0; i < 400 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (rsp_cnt >= target) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req_valid = '1;
    @(posedge clk);
    #1;
    total_cnt++;
    if (req_ready !== '0) $display("FAIL rst_ready got %b want 0", req_ready);
    else pass_cnt++;
    total_cnt++;
    if (rsp_valid !== '0) $display("FAIL rst_rsp_valid got %b want 0", rsp_valid);
    else pass_cnt++;
    total_cnt++;
    if (rsp_y !== '0) $display("FAIL rst_rsp_y got %h want 0", rsp_y);
    else pass_cnt++;
    total_cnt++;
    if (rsp_err !== 1'b0) $display("FAIL rst_rsp_err got %b want 0", rsp_err);
    else pass_cnt++;
    total_cnt++;
    if (sq_req !== 1'b0) $display("FAIL rst_sq_req got %b want 0", sq_req);
    else pass_cnt++;
    total_cnt++;
    if (sq_x !== '0) $display("FAIL rst_sq_x got %h want 0", sq_x);
    else pass_cnt++;
    req_valid = '0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back;
    int a0;
    int n0;
    bit ok;
    fin_dly = 3;
    fall_dly = 1;
    grant_q.delete();
    a0 = acc_cnt;
    n0 = rsp_cnt;
    for (int i = 0; i < N; i++) req_x[i*W +: W] = 32'(i + 1);
    req_valid = '1;
    for (int i = 0; i < 800 && acc_cnt < a0 + 5; i++) begin
      @(posedge clk);
      #1;
    end
    req_valid = '0;
    total_cnt++;
    if (acc_cnt != a0 + 5)
      $display("FAIL b2b_accepts got %0d want %0d", acc_cnt - a0, 5);
    else pass_cnt++;
    wait_rsp(n0 + 5, ok);
    total_cnt++;
    if (!ok) $display("FAIL b2b_rsp_count got %0d want %0d", rsp_cnt - n0, 5);
    else pass_cnt++;
    for (int k = 0; k < 5; k++) begin
      total_cnt++;
      if (k >= grant_q.size())
        $display("FAIL b2b_order[%0d] got none want %0d", k, k % N);
      else if (grant_q[k] != k % N)
        $display("FAIL b2b_order[%0d] got %0d want %0d", k, grant_q[k], k % N);
      else pass_cnt++;
    end
  endtask

  task automatic test_single;
    int n0;
    bit ok;
    fin_dly = 7;
    n0 = rsp_cnt;
    issue(2, 32'h0000_0100, ok);
    total_cnt++;
    if (!ok) $display("FAIL single_accept got none want accept");
    else pass_cnt++;
    wait_rsp(n0 + 1, ok);
    total_cnt++;
    if (!ok) $display("FAIL single_rsp got none want rsp");
    else pass_cnt++;
    total_cnt++;
    if (sqreq_cyc - acc_cyc != 2)
      $display("FAIL single_sqreq_lat got %0d want 2", sqreq_cyc - acc_cyc);
    else pass_cnt++;
    total_cnt++;
    if (rsp_cyc - acc_cyc != 5 + 7)
      $display("FAIL single_lat got %0d want %0d", rsp_cyc - acc_cyc, 12);
    else pass_cnt++;
    total_cnt++;
    if (last_rv !== 4'b0100 || last_y !== 32'h10 || last_err !== 1'b0)
      $display("FAIL single_result got %b/%h/%b want 0100/10/0",
               last_rv, last_y, last_err);
    else pass_cnt++;
  endtask

  task automatic test_fast_fin;
    int n0;
    bit ok;
    fin_dly = 0;
    n0 = rsp_cnt;
    issue(1, 32'd144, ok);
    wait_rsp(n0 + 1, ok);
    total_cnt++;
    if (!ok) $display("FAIL fast_rsp got none want rsp");
    else pass_cnt++;
    total_cnt++;
    if (rsp_cyc - sqreq_cyc != 3)
      $display("FAIL fast_req_to_strobe got %0d want 3", rsp_cyc - sqreq_cyc);
    else pass_cnt++;
    total_cnt++;
    if (rsp_cyc - acc_cyc != 5)
      $display("FAIL fast_lat got %0d want 5", rsp_cyc - acc_cyc);
    else pass_cnt++;
  endtask

  task automatic test_drop_valid;
    int a0;
    int n0;
    bit ok;
    fin_dly = 6;
    n0 = rsp_cnt;
    issue(1, 32'd49, ok);
    a0 = acc_cnt;
    req_valid[2] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    req_valid[2] = 1'b0;
    total_cnt++;
    if (acc_cnt != a0) $display("FAIL drop_no_grant got %0d want 0", acc_cnt - a0);
    else pass_cnt++;
    wait_rsp(n0 + 1, ok);
    req_x[0*W +: W] = 32'd400;
    req_x[2*W +: W] = 32'd900;
    req_valid = 4'b0101;
    for (int i = 0; i < 200 && acc_cnt == a0; i++) begin
      @(posedge clk);
      #1;
    end
    req_valid[2] = 1'b0;
    total_cnt++;
    if (acc_cnt != a0 + 1 || grant_q[$] != 2)
      $display("FAIL drop_next_winner got %0d want 2", grant_q[$]);
    else pass_cnt++;
    for (int i = 0; i < 200 && acc_cnt == a0 + 1; i++) begin
      @(posedge clk);
      #1;
    end
    req_valid = '0;
    total_cnt++;
    if (acc_cnt != a0 + 2 || grant_q[$] != 0)
      $display("FAIL drop_second_winner got %0d want 0", grant_q[$]);
    else pass_cnt++;
    wait_rsp(n0 + 3, ok);
    total_cnt++;
    if (!ok) $display("FAIL drop_rsp got %0d want %0d", rsp_cnt - n0, 3);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    int n0;
    int bad;
    bit ok;
    bit seen;
    fin_dly = 2;
    fall_dly = 6;
    issue(0, 32'd10000, ok);
    for (int i = 0; i < 50 && !sq_req; i++) begin
      @(posedge clk);
      #1;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    total_cnt++;
    if (sq_req !== 1'b0) $display("FAIL rmid_sq_req got %b want 0", sq_req);
    else pass_cnt++;
    total_cnt++;
    if (rsp_y !== '0) $display("FAIL rmid_rsp_y got %h want 0", rsp_y);
    else pass_cnt++;
    n0 = rsp_cnt;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    req_x[3*W +: W] = 32'd64;
    req_valid[3] = 1'b1;
    bad = 0;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (sq_fin) begin
        if (req_ready != '0) bad++;
        @(posedge clk);
        #1;
      end else seen = 1'b1;
    end
    total_cnt++;
    if (bad != 0 || !seen)
      $display("FAIL rmid_ready_while_fin got %0d want 0", bad);
    else pass_cnt++;
    total_cnt++;
    if (req_ready !== '0)
      $display("FAIL rmid_ready_before_sync got %b want 0", req_ready);
    else pass_cnt++;
    @(posedge clk);
    #1;
    total_cnt++;
    if (req_ready !== 4'b1000)
      $display("FAIL rmid_first_ready got %b want 1000", req_ready);
    else pass_cnt++;
    total_cnt++;
    if (rsp_cnt != n0)
      $display("FAIL rmid_discard got %0d want 0", rsp_cnt - n0);
    else pass_cnt++;
    @(posedge clk);
    #1;
    req_valid = '0;
    wait_rsp(n0 + 1, ok);
    total_cnt++;
    if (!ok || last_y !== 32'd8)
      $display("FAIL rmid_after_rsp got %h want 8", last_y);
    else pass_cnt++;
    fall_dly = 1;
  endtask

  task automatic test_timeout;
    int n0;
    bit ok;
    fin_dly = 1;
    n0 = rsp_cnt;
    repeat (12) @(posedge clk);
    #1;
    never_fin = 1'b1;
    issue(2, 32'd81, ok);
`ifdef SQRT_ARB_TIMEOUT_EN
    wait_rsp(n0 + 1, ok);
    total_cnt++;
    if (!ok) $display("FAIL tmo_rsp got none want rsp");
    else pass_cnt++;
    total_cnt++;
    if (rsp_cyc - acc_cyc != 1 + TO)
      $display("FAIL tmo_lat got %0d want %0d", rsp_cyc - acc_cyc, 1 + TO);
    else pass_cnt++;
    total_cnt++;
    if (last_err !== 1'b1 || last_y !== '0)
      $display("FAIL tmo_result got %b/%h want 1/0", last_err, last_y);
    else pass_cnt++;
    repeat (4) @(posedge clk);
    #1;
    never_fin = 1'b0;
`else
    repeat (3 * TO) @(posedge clk);
    #1;
    total_cnt++;
    if (rsp_cnt != n0 || sq_req !== 1'b1)
      $display("FAIL notmo_stuck got rsp=%0d sq_req=%b want 0/1",
               rsp_cnt - n0, sq_req);
    else pass_cnt++;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    never_fin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
`endif
  endtask

  task automatic test_random;
    int n0;
    int r;
    int d;
    bit ok;
    for (int k = 0; k < 6; k++) begin
      r = $urandom_range(N - 1, 0);
      d = $urandom_range(5, 0);
      fin_dly = d;
      n0 = rsp_cnt;
      issue(r, $urandom, ok);
      wait_rsp(n0 + 1, ok);
      total_cnt++;
      if (!ok || rsp_cyc - acc_cyc != 5 + d)
        $display("FAIL rand_lat[%0d] got %0d want %0d", k,
                 rsp_cyc - acc_cyc, 5 + d);
      else pass_cnt++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_single();
    test_fast_fin();
    test_drop_valid();
    test_reset_mid();
    test_timeout();
    test_random();
    repeat (5) @(posedge clk);
    #1;
    total_cnt++;
    if (sb_q.size() != 0)
      $display("FAIL sb_drain got %0d want 0", sb_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
